regfile_write_scheduler: RTL and testbench

- Owns the single write port of the 32-entry integer register file in the single-cycle RISC-V core.
- Drives the per-register ClockEnable lines and the shared D bus feeding the register flip-flop instances.
- Sequences a post-reset zero-clear sweep, then arbitrates each Tick between CPU writeback and the debug/loader port.
- Keeps x0 permanently unwritten; bounds debug-port starvation with a stall-based override.

---
 rtl/regfile_write_scheduler.sv | 136 +++++++++++++
 tb/tb_regfile_write_scheduler.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_scheduler.sv
// rtl/regfile_write_scheduler.sv - write-port scheduler for the 32-entry integer register file
//
// Purpose: owns the single register-file write port. After reset it sweeps
// zeros into x1..x(NrOfRegs-1), then each Tick grants the port to CPU
// writeback or to the debug/loader port, with a stall-based override that
// bounds how long a pending debug write can be starved. x0 is never written.
//
// Ports:
//   Clock      in   system clock, rising edge
//   Reset      in   asynchronous active-low reset
//   Tick       in   global clock enable; state advances only when high
//   cpu_we     in   CPU writeback request
//   cpu_addr   in   CPU destination register
//   cpu_data   in   CPU writeback data
//   dbg_req    in   debug write request (level, held until dbg_ack)
//   dbg_addr   in   debug destination register
//   dbg_data   in   debug write data
//   dbg_ack    out  one-Tick pulse: debug write committed
//   rf_we      out  one-hot per-register clock enable (bit 0 always 0)
//   rf_d       out  shared D bus to all registers
//   cpu_stall  out  CPU must hold its PC/instruction this Tick
//   busy       out  clear sweep in progress
module regfile_write_scheduler #(
  parameter int NrOfBits    = 32,
  parameter int NrOfRegs    = 32,
  parameter int AddrBits    = 5,
  parameter int StarveLimit = 4
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic                cpu_we,
  input  logic [AddrBits-1:0] cpu_addr,
  input  logic [NrOfBits-1:0] cpu_data,
  input  logic                dbg_req,
  input  logic [AddrBits-1:0] dbg_addr,
  input  logic [NrOfBits-1:0] dbg_data,
  output logic                dbg_ack,
  output logic [NrOfRegs-1:0] rf_we,
  output logic [NrOfBits-1:0] rf_d,
  output logic                cpu_stall,
  output logic                busy
);

  typedef enum logic {
    CLEAR,
    RUN
  } state_t;

  localparam logic [3:0]          LIMIT    = 4'(StarveLimit);
  localparam logic [AddrBits-1:0] LAST_REG = AddrBits'(NrOfRegs - 1);

  state_t              state, state_next;
  logic [AddrBits-1:0] clr_ptr, clr_ptr_next;
  logic [3:0]          starve_cnt, starve_next;
  logic                ack_next;
  logic                cpu_grant, dbg_grant;
  logic [NrOfRegs-1:0] we_sel;

  // Decoded enable with x0 masked out: a grant to x0 is a silent no-op write.
  function automatic logic [NrOfRegs-1:0] onehot_nz(input logic [AddrBits-1:0] a);
    logic [NrOfRegs-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    v[0] = 1'b0;
    return v;
  endfunction

  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    starve_next  = starve_cnt;
    ack_next     = dbg_ack;
    cpu_grant    = 1'b0;
    dbg_grant    = 1'b0;
    we_sel       = '0;
    rf_d         = '0;
    cpu_stall    = 1'b1;
    busy         = 1'b1;

    if (state == CLEAR) begin
      we_sel       = onehot_nz(clr_ptr);
      clr_ptr_next = clr_ptr + AddrBits'(1);
      starve_next  = 4'd0;
      ack_next     = 1'b0;
      if (clr_ptr == LAST_REG) begin
        state_next = RUN;
      end
    end else begin
      busy      = 1'b0;
      cpu_grant = cpu_we && (starve_cnt < LIMIT);
      // A high dbg_ack means this request was just serviced; blocking the
      // grant on that Tick prevents a double write before the requester
      // drops dbg_req.
      dbg_grant = dbg_req && !dbg_ack && (!cpu_we || (starve_cnt >= LIMIT));

      if (dbg_grant) begin
        we_sel = onehot_nz(dbg_addr);
        rf_d   = dbg_data;
      end else if (cpu_grant) begin
        we_sel = onehot_nz(cpu_addr);
        rf_d   = cpu_data;
      end

      // Any CPU writeback that did not get the port must be held, so it is
      // retried rather than lost (covers the debug override case).
      cpu_stall = cpu_we && !cpu_grant;
      ack_next  = dbg_grant;

      if (dbg_grant || !dbg_req) begin
        starve_next = 4'd0;
      end else if (!dbg_ack && (starve_cnt != 4'hF)) begin
        starve_next = starve_cnt + 4'd1;
      end
    end
  end

  // Enables are qualified by Tick and by reset so the register file never
  // captures while the scheduler is frozen or being reset.
  assign rf_we = (Tick && Reset) ? we_sel : '0;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= CLEAR;
      clr_ptr    <= AddrBits'(1);
      starve_cnt <= 4'd0;
      dbg_ack    <= 1'b0;
    end else if (Tick) begin
      state      <= state_next;
      clr_ptr    <= clr_ptr_next;
      starve_cnt <= starve_next;
      dbg_ack    <= ack_next;
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb/tb_regfile_write_scheduler.sv - scoreboard bench for regfile_write_scheduler
module tb_regfile_write_scheduler;

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Tick = 1'b0;
  logic        cpu_we = 1'b0;
  logic [4:0]  cpu_addr = '0;
  logic [31:0] cpu_data = '0;
  logic        dbg_req = 1'b0;
  logic [4:0]  dbg_addr = '0;
  logic [31:0] dbg_data = '0;
  logic        dbg_ack;
  logic [31:0] rf_we;
  logic [31:0] rf_d;
  logic        cpu_stall;
  logic        busy;

  regfile_write_scheduler dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .dbg_ack(dbg_ack), .rf_we(rf_we), .rf_d(rf_d),
    .cpu_stall(cpu_stall), .busy(busy)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [31:0] we;
    logic [31:0] d;
    logic        stall;
    logic        busy;
    logic        ack;
  } vec_t;

  vec_t  exp_q[$];
  string tag_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  function automatic vec_t mk(input logic [31:0] we, input logic [31:0] d,
                              input logic st, input logic bz, input logic ak);
    vec_t v;
    v.we = we; v.d = d; v.stall = st; v.busy = bz; v.ack = ak;
    return v;
  endfunction

  task automatic set_in(input logic tk, input logic cw, input logic [4:0] ca, input logic [31:0] cd,
                        input logic dr, input logic [4:0] da, input logic [31:0] dd);
    Tick = tk; cpu_we = cw; cpu_addr = ca; cpu_data = cd;
    dbg_req = dr; dbg_addr = da; dbg_data = dd;
  endtask

  task automatic test_reset();
    vec_t e, o;
    string t;
    for (int i = 0; i < 2; i++) begin
      @(posedge Clock); #1;
      set_in(1'b1, 1'b1, 5'd5, 32'h1111, 1'b1, 5'd3, 32'h2222);
      exp_q.push_back(mk(32'h0, 32'h0, 1'b1, 1'b1, 1'b0));
      tag_q.push_back($sformatf("reset_%0d", i));
      @(negedge Clock);
      e = exp_q.pop_front(); t = tag_q.pop_front();
      o = {rf_we, rf_d, cpu_stall, busy, dbg_ack}; n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got we=%h d=%h stall=%b busy=%b ack=%b, want we=%h d=%h stall=%b busy=%b ack=%b",
                 t, o.we, o.d, o.stall, o.busy, o.ack, e.we, e.d, e.stall, e.busy, e.ack);
      end
    end
  endtask

  task automatic test_clear_sweep();
    vec_t e, o;
    string t;
    for (int i = 1; i <= 32; i++) begin
      @(posedge Clock); #1;
      if (i == 1) Reset = 1'b1;
      if (i <= 31) begin
        // requests during the sweep must be ignored
        set_in(1'b1, 1'b1, 5'd9, 32'hFFFF_0000, 1'b1, 5'd3, 32'h3333);
        exp_q.push_back(mk(32'd1 << i, 32'h0, 1'b1, 1'b1, 1'b0));
      end else begin
        set_in(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        exp_q.push_back(mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
      end
      tag_q.push_back($sformatf("sweep_%0d", i));
      @(negedge Clock);
      e = exp_q.pop_front(); t = tag_q.pop_front();
      o = {rf_we, rf_d, cpu_stall, busy, dbg_ack}; n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got we=%h d=%h stall=%b busy=%b ack=%b, want we=%h d=%h stall=%b busy=%b ack=%b",
                 t, o.we, o.d, o.stall, o.busy, o.ack, e.we, e.d, e.stall, e.busy, e.ack);
      end
    end
  endtask

  task automatic test_cpu_write();
    vec_t e, o;
    string t;
    logic [4:0]  a[3] = '{5'd5, 5'd31, 5'd1};
    logic [31:0] d[3] = '{32'hDEAD_BEEF, 32'h0000_0000, 32'hCAFE_F00D};
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      set_in(1'b1, 1'b1, a[i], d[i], 1'b0, 5'd0, 32'h0);
      exp_q.push_back(mk(32'd1 << a[i], d[i], 1'b0, 1'b0, 1'b0));
      tag_q.push_back($sformatf("cpu_write_%0d", i));
      @(negedge Clock);
      e = exp_q.pop_front(); t = tag_q.pop_front();
      o = {rf_we, rf_d, cpu_stall, busy, dbg_ack}; n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got we=%h d=%h stall=%b busy=%b ack=%b, want we=%h d=%h stall=%b busy=%b ack=%b",
                 t, o.we, o.d, o.stall, o.busy, o.ack, e.we, e.d, e.stall, e.busy, e.ack);
      end
    end
  endtask

  task automatic test_dbg_write();
    vec_t e, o;
    string t;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      // request held through the ack Tick, dropped after the ack is seen
      set_in(1'b1, 1'b0, 5'd0, 32'h0, (i < 2), 5'd3, 32'h1234_5678);
      case (i)
        0: exp_q.push_back(mk(32'h0000_0008, 32'h1234_5678, 1'b0, 1'b0, 1'b0));
        1: exp_q.push_back(mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b1));
        default: exp_q.push_back(mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
      endcase
      tag_q.push_back($sformatf("dbg_write_%0d", i));
      @(negedge Clock);
      e = exp_q.pop_front(); t = tag_q.pop_front();
      o = {rf_we, rf_d, cpu_stall, busy, dbg_ack}; n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got we=%h d=%h stall=%b busy=%b ack=%b, want we=%h d=%h stall=%b busy=%b ack=%b",
                 t, o.we, o.d, o.stall, o.busy, o.ack, e.we, e.d, e.stall, e.busy, e.ack);
      end
    end
  endtask

  task automatic test_starvation();
    vec_t e, o;
    string t;
    logic [31:0] cd;
    for (int i = 1; i <= 7; i++) begin
      @(posedge Clock); #1;
      cd = 32'hA5A5_0000 + 32'(i);
      set_in(1'b1, 1'b1, 5'd10, cd, (i <= 6), 5'd7, 32'h0000_0077);
      if (i <= 4)      exp_q.push_back(mk(32'h0000_0400, cd, 1'b0, 1'b0, 1'b0));
      else if (i == 5) exp_q.push_back(mk(32'h0000_0080, 32'h0000_0077, 1'b1, 1'b0, 1'b0));
      else if (i == 6) exp_q.push_back(mk(32'h0000_0400, cd, 1'b0, 1'b0, 1'b1));
      else             exp_q.push_back(mk(32'h0000_0400, cd, 1'b0, 1'b0, 1'b0));
      tag_q.push_back($sformatf("starve_%0d", i));
      @(negedge Clock);
      e = exp_q.pop_front(); t = tag_q.pop_front();
      o = {rf_we, rf_d, cpu_stall, busy, dbg_ack}; n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got we=%h d=%h stall=%b busy=%b ack=%b, want we=%h d=%h stall=%b busy=%b ack=%b",
                 t, o.we, o.d, o.stall, o.busy, o.ack, e.we, e.d, e.stall, e.busy, e.ack);
      end
    end
  endtask

  task automatic test_x0_mask();
    vec_t e, o;
    string t;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clock); #1;
      case (i)
        0: begin
          set_in(1'b1, 1'b1, 5'd0, 32'h0000_FFFF, 1'b0, 5'd0, 32'h0);
          exp_q.push_back(mk(32'h0, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0));
        end
        1: begin
          set_in(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0000_0055);
          exp_q.push_back(mk(32'h0, 32'h0000_0055, 1'b0, 1'b0, 1'b0));
        end
        2: begin
          set_in(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h0000_0055);
          exp_q.push_back(mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b1));
        end
        default: begin
          set_in(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
          exp_q.push_back(mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b0));
        end
      endcase
      tag_q.push_back($sformatf("x0_mask_%0d", i));
      @(negedge Clock);
      e = exp_q.pop_front(); t = tag_q.pop_front();
      o = {rf_we, rf_d, cpu_stall, busy, dbg_ack}; n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got we=%h d=%h stall=%b busy=%b ack=%b, want we=%h d=%h stall=%b busy=%b ack=%b",
                 t, o.we, o.d, o.stall, o.busy, o.ack, e.we, e.d, e.stall, e.busy, e.ack);
      end
    end
  endtask

  task automatic test_tick_gating();
    vec_t e, o;
    string t;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clock); #1;
      case (i)
        0: begin
          set_in(1'b0, 1'b1, 5'd4, 32'h4444_4444, 1'b0, 5'd0, 32'h0);
          exp_q.push_back(mk(32'h0, 32'h4444_4444, 1'b0, 1'b0, 1'b0));
        end
        1, 2: begin
          // frozen: no grant is committed, so no ack appears
          set_in(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h6666_6666);
          exp_q.push_back(mk(32'h0, 32'h6666_6666, 1'b0, 1'b0, 1'b0));
        end
        3: begin
          set_in(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h6666_6666);
          exp_q.push_back(mk(32'h0000_0040, 32'h6666_6666, 1'b0, 1'b0, 1'b0));
        end
        default: begin
          set_in(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
          exp_q.push_back(mk(32'h0, 32'h0, 1'b0, 1'b0, 1'b1));
        end
      endcase
      tag_q.push_back($sformatf("tick_gate_%0d", i));
      @(negedge Clock);
      e = exp_q.pop_front(); t = tag_q.pop_front();
      o = {rf_we, rf_d, cpu_stall, busy, dbg_ack}; n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got we=%h d=%h stall=%b busy=%b ack=%b, want we=%h d=%h stall=%b busy=%b ack=%b",
                 t, o.we, o.d, o.stall, o.busy, o.ack, e.we, e.d, e.stall, e.busy, e.ack);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    vec_t e, o;
    string t;
    // cycle 0: reset; 1..10: sweep x1..x10; 11: async reset mid-cycle;
    // 12..14: released with Tick=0; 15..16: sweep restarts at x1
    for (int i = 0; i <= 16; i++) begin
      if (i != 11) begin
        @(posedge Clock); #1;
      end
      if (i == 0) begin
        Reset = 1'b0;
        set_in(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        exp_q.push_back(mk(32'h0, 32'h0, 1'b1, 1'b1, 1'b0));
      end else if (i <= 10) begin
        Reset = 1'b1;
        exp_q.push_back(mk(32'd1 << i, 32'h0, 1'b1, 1'b1, 1'b0));
      end else if (i == 11) begin
        #2 Reset = 1'b0;
        exp_q.push_back(mk(32'h0, 32'h0, 1'b1, 1'b1, 1'b0));
      end else if (i <= 14) begin
        Reset = 1'b1;
        Tick  = 1'b0;
        exp_q.push_back(mk(32'h0, 32'h0, 1'b1, 1'b1, 1'b0));
      end else begin
        Tick = 1'b1;
        exp_q.push_back(mk(32'd1 << (i - 14), 32'h0, 1'b1, 1'b1, 1'b0));
      end
      tag_q.push_back($sformatf("reset_mid_%0d", i));
      if (i == 11) #1;
      else @(negedge Clock);
      e = exp_q.pop_front(); t = tag_q.pop_front();
      o = {rf_we, rf_d, cpu_stall, busy, dbg_ack}; n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL %s: got we=%h d=%h stall=%b busy=%b ack=%b, want we=%h d=%h stall=%b busy=%b ack=%b",
                 t, o.we, o.d, o.stall, o.busy, o.ack, e.we, e.d, e.stall, e.busy, e.ack);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_clear_sweep();
    test_cpu_write();
    test_dbg_write();
    test_starvation();
    test_x0_mask();
    test_tick_gating();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
